// File: rtl/iguana_hyper_cfg_seq.sv
// Boot-time configuration sequencer for the Hyperbus register port: waits for
// HyperRAM power-up, programs three timing registers, then passes software traffic through.
module iguana_hyper_cfg_seq #(
  parameter int unsigned          AddrWidth     = 48,
  parameter int unsigned          DataWidth     = 32,
  parameter logic [AddrWidth-1:0] CfgBase       = 'h4000_0000,
  parameter int unsigned          InitDelay     = 200,
  parameter int unsigned          TimeoutCycles = 1024,
  parameter int unsigned          MaxRetries    = 2,
  parameter logic [DataWidth-1:0] CfgLatency    = 'h6,
  parameter logic [DataWidth-1:0] CfgBurstMax   = 'h15E,
  parameter logic [DataWidth-1:0] CfgRwRecovery = 'h6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   restart_i,
  input  logic                   s_req_valid_i,
  input  logic                   s_req_write_i,
  input  logic [AddrWidth-1:0]   s_req_addr_i,
  input  logic [DataWidth-1:0]   s_req_wdata_i,
  input  logic [DataWidth/8-1:0] s_req_wstrb_i,
  output logic                   s_rsp_ready_o,
  output logic                   s_rsp_error_o,
  output logic [DataWidth-1:0]   s_rsp_rdata_o,
  output logic                   m_req_valid_o,
  output logic                   m_req_write_o,
  output logic [AddrWidth-1:0]   m_req_addr_o,
  output logic [DataWidth-1:0]   m_req_wdata_o,
  output logic [DataWidth/8-1:0] m_req_wstrb_o,
  input  logic                   m_rsp_ready_i,
  input  logic                   m_rsp_error_i,
  input  logic [DataWidth-1:0]   m_rsp_rdata_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int unsigned TmoWidth = $clog2(TimeoutCycles + 1);
  localparam int unsigned RtyWidth = $clog2(MaxRetries + 2);

  typedef enum logic [1:0] {StWait, StWrite, StDone, StFail} state_e;

  state_e              state_q;
  logic [15:0]         dly_q;
  logic [1:0]          idx_q;
  logic [RtyWidth-1:0] rty_q;
  logic [TmoWidth-1:0] tmo_q;
  logic                gap_q, pend_q, busy_q, done_q, err_q;

  logic [AddrWidth-1:0] seq_addr;
  logic [DataWidth-1:0] seq_data;
  logic                 seq_valid, pass, timeout, last_try;

  always_comb begin
    seq_addr = CfgBase;
    seq_data = CfgLatency;
    case (idx_q)
      2'd1: begin
        seq_addr = CfgBase + AddrWidth'('h4);
        seq_data = CfgBurstMax;
      end
      2'd2: begin
        seq_addr = CfgBase + AddrWidth'('h8);
        seq_data = CfgRwRecovery;
      end
      default: ;
    endcase
  end

  assign seq_valid = (state_q == StWrite) && !gap_q;
  assign pass      = (state_q == StDone) || (state_q == StFail);
  assign timeout   = !m_rsp_ready_i && (tmo_q == TmoWidth'(TimeoutCycles - 1));
  assign last_try  = (rty_q == RtyWidth'(MaxRetries));

  // Sequencer-owned request is decoded from state only; m_rsp never reaches m_req here.
  assign m_req_valid_o = pass ? s_req_valid_i : seq_valid;
  assign m_req_write_o = pass ? s_req_write_i : seq_valid;
  assign m_req_addr_o  = pass ? s_req_addr_i  : (seq_valid ? seq_addr : '0);
  assign m_req_wdata_o = pass ? s_req_wdata_i : (seq_valid ? seq_data : '0);
  assign m_req_wstrb_o = pass ? s_req_wstrb_i : (seq_valid ? '1 : '0);

  assign s_rsp_ready_o = pass & m_rsp_ready_i;
  assign s_rsp_error_o = pass & m_rsp_error_i;
  assign s_rsp_rdata_o = pass ? m_rsp_rdata_i : '0;

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StWait;
      dly_q   <= '0;
      idx_q   <= '0;
      rty_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StWait: begin
          if (dly_q == 16'(InitDelay - 1)) begin
            state_q <= StWrite;
            dly_q   <= '0;
            idx_q   <= '0;
            rty_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= 1'b0;
          end else begin
            dly_q <= dly_q + 16'd1;
          end
        end
        StWrite: begin
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (m_rsp_ready_i && !m_rsp_error_i) begin
            rty_q <= '0;
            tmo_q <= '0;
            if (idx_q == 2'd2) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end else if (m_rsp_ready_i || timeout) begin
            tmo_q <= '0;
            if (last_try) begin
              state_q <= StFail;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              rty_q <= rty_q + 1'b1;
              // a timed-out attempt idles one cycle; an errored one re-issues at once
              gap_q <= !m_rsp_ready_i;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: begin
          // wait for the upstream bus to go idle so an in-flight access is never cut
          if (pend_q && !s_req_valid_i) begin
            state_q <= StWait;
            dly_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end else if (restart_i) begin
            pend_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
